lcd_pattern_gen: RTL and testbench



---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_pattern_gen_if.sv | 27 ++
 rtl/lcd_pattern_pixel.sv | 49 ++++
 rtl/lcd_pattern_gen.sv | 97 +++++++++
 tb/tb_lcd_pattern_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, pattern-mode encoding and colour lookup for the LCD pattern source
package lcd_pkg;

    localparam int LCD_H_ACTIVE  = 480;
    localparam int LCD_V_ACTIVE  = 272;
    localparam int LCD_CHK_SHIFT = 4;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } pattern_mode_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Colour bars, left to right
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// rtl/lcd_pattern_gen_if.sv - pixel stream handshake between pattern source and lcd_driver
interface lcd_pattern_gen_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        output pix_eol,
        output frame_done,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        input  pix_eol,
        input  frame_done,
        output pix_ready
    );
endinterface

// File: rtl/lcd_pattern_pixel.sv
// rtl/lcd_pattern_pixel.sv - combinational pixel function f(x,y,mode,color); PATTERN_BORDER_EN adds a white outline
module lcd_pattern_pixel
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE  = LCD_H_ACTIVE,
    parameter int V_ACTIVE  = LCD_V_ACTIVE,
    parameter int CHK_SHIFT = LCD_CHK_SHIFT,
    parameter int XW        = $clog2(H_ACTIVE),
    parameter int YW        = $clog2(V_ACTIVE)
) (
    input  logic [XW-1:0]  x,
    input  logic [YW-1:0]  y,
    input  pattern_mode_t  mode,
    input  logic [15:0]    color,
    output logic [15:0]    pixel
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [15:0] xe;
    logic [15:0] ye;
    logic [15:0] bar_idx;
    logic [2:0]  bar_sat;
    logic [15:0] base;

    // Pattern value for the given position; coordinates are widened so gradient bit slices exist for small panels
    always_comb begin
        xe      = 16'(x);
        ye      = 16'(y);
        bar_idx = xe / 16'(BAR_W);
        bar_sat = (bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0];
        case (mode)
            MODE_BARS:     base = bar_color(bar_sat);
            MODE_CHECKER:  base = ((((xe >> CHK_SHIFT) ^ (ye >> CHK_SHIFT)) & 16'd1) != 16'd0)
                                  ? RGB_BLACK : RGB_WHITE;
            MODE_GRADIENT: base = {xe[8:4], xe[8:3], xe[8:4]};
            default:       base = color;
        endcase
`ifdef PATTERN_BORDER_EN
        if (x == '0 || x == XW'(H_ACTIVE - 1) || y == '0 || y == YW'(V_ACTIVE - 1))
            pixel = RGB_WHITE;
        else
            pixel = base;
`else
        pixel = base;
`endif
    end

endmodule

// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - raster RGB565 test-pattern source (optional macro PATTERN_BORDER_EN)
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE  = LCD_H_ACTIVE,
    parameter int V_ACTIVE  = LCD_V_ACTIVE,
    parameter int CHK_SHIFT = LCD_CHK_SHIFT
) (
    input  logic                 lcd_clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [15:0]          solid_color,
    input  logic                 resync,
    lcd_pattern_gen_if.master    pix
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    logic [XW-1:0]  x, x_d;
    logic [YW-1:0]  y, y_d;
    pattern_mode_t  mode_q, mode_d;
    logic [15:0]    color_q, color_d;
    logic           done_d;
    logic           fire;
    logic [15:0]    pixel_d;

    // Next raster position and latched config; startup and resync both restart at (0,0) with fresh settings
    always_comb begin
        x_d     = x;
        y_d     = y;
        mode_d  = mode_q;
        color_d = color_q;
        done_d  = 1'b0;
        fire    = pix.pix_valid & pix.pix_ready;
        if (!pix.pix_valid || resync) begin
            x_d     = '0;
            y_d     = '0;
            mode_d  = pattern_mode_t'(mode);
            color_d = solid_color;
        end else if (fire) begin
            if (x == XW'(H_ACTIVE - 1)) begin
                x_d = '0;
                if (y == YW'(V_ACTIVE - 1)) begin
                    y_d     = '0;
                    done_d  = 1'b1;
                    mode_d  = pattern_mode_t'(mode);
                    color_d = solid_color;
                end else begin
                    y_d = y + YW'(1);
                end
            end else begin
                x_d = x + XW'(1);
            end
        end
    end

    lcd_pattern_pixel #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .CHK_SHIFT (CHK_SHIFT),
        .XW        (XW),
        .YW        (YW)
    ) u_pixel (
        .x     (x_d),
        .y     (y_d),
        .mode  (mode_d),
        .color (color_d),
        .pixel (pixel_d)
    );

    // Position, config latch and output registers; outputs describe the pixel at (x,y) and hold while stalled
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            x              <= '0;
            y              <= '0;
            mode_q         <= MODE_BARS;
            color_q        <= '0;
            pix.pix_valid  <= 1'b0;
            pix.pix_data   <= '0;
            pix.pix_sof    <= 1'b0;
            pix.pix_eol    <= 1'b0;
            pix.frame_done <= 1'b0;
        end else begin
            x              <= x_d;
            y              <= y_d;
            mode_q         <= mode_d;
            color_q        <= color_d;
            pix.pix_valid  <= 1'b1;
            pix.pix_data   <= pixel_d;
            pix.pix_sof    <= (x_d == '0) && (y_d == '0);
            pix.pix_eol    <= (x_d == XW'(H_ACTIVE - 1));
            pix.frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb/tb_lcd_pattern_gen.sv - self-checking bench for lcd_pattern_gen on a reduced 64x24 raster
module tb_lcd_pattern_gen;

    localparam int H  = 64;
    localparam int V  = 24;
    localparam int FR = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        resync = 1'b0;
    int          checks = 0;
    int          errors = 0;

    lcd_pattern_gen_if pix_if ();

    lcd_pattern_gen #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .CHK_SHIFT (4)
    ) dut (
        .lcd_clk     (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .solid_color (solid_color),
        .resync      (resync),
        .pix         (pix_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [15:0] c;
        int          x;
        int          y;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] with_border(input int bx, input int by, input logic [15:0] d);
`ifdef PATTERN_BORDER_EN
        if (bx == 0 || bx == H - 1 || by == 0 || by == V - 1)
            return 16'hFFFF;
`endif
        return d;
    endfunction

    // Restart the frame with the given settings, then advance to (gx,gy) and stall there
    task automatic goto(input logic [1:0] m, input logic [15:0] c, input int gx, input int gy);
        @(negedge clk);
        mode = m;
        solid_color = c;
        resync = 1'b1;
        pix_if.pix_ready = 1'b0;
        @(negedge clk);
        resync = 1'b0;
        pix_if.pix_ready = 1'b1;
        repeat (gy * H + gx) @(negedge clk);
        pix_if.pix_ready = 1'b0;
    endtask

    initial begin
        int          fires;
        int          frames;
        int          px;
        int          py;
        int          cyc;
        logic        last_ready;
        logic [15:0] s_data;
        logic        s_sof;
        logic        s_eol;

        vecs.push_back('{"bar0",     2'd0, 16'h0, 0,  0,  16'hFFFF});
        vecs.push_back('{"bar1",     2'd0, 16'h0, 8,  0,  16'hFFE0});
        vecs.push_back('{"bar2",     2'd0, 16'h0, 23, 3,  16'h07FF});
        vecs.push_back('{"bar5",     2'd0, 16'h0, 40, 1,  16'hF800});
        vecs.push_back('{"bar7",     2'd0, 16'h0, 63, 0,  16'h0000});
        vecs.push_back('{"chk00",    2'd1, 16'h0, 0,  0,  16'hFFFF});
        vecs.push_back('{"chk16_0",  2'd1, 16'h0, 16, 0,  16'h0000});
        vecs.push_back('{"chk16_16", 2'd1, 16'h0, 16, 16, 16'hFFFF});
        vecs.push_back('{"chk48_0",  2'd1, 16'h0, 48, 0,  16'h0000});
        vecs.push_back('{"chk63_23", 2'd1, 16'h0, 63, 23, 16'hFFFF});
        vecs.push_back('{"grad0",    2'd2, 16'h0, 0,  0,  16'h0000});
        vecs.push_back('{"grad40",   2'd2, 16'h0, 40, 5,  16'h10A2});
        vecs.push_back('{"grad63",   2'd2, 16'h0, 63, 0,  16'h18E3});
        vecs.push_back('{"solid",    2'd3, 16'h1234, 10, 10, 16'h1234});
`ifdef PATTERN_BORDER_EN
        vecs.push_back('{"bord_l",   2'd3, 16'h001F, 0,  5,  16'hFFFF});
        vecs.push_back('{"bord_r",   2'd3, 16'h001F, 63, 5,  16'hFFFF});
        vecs.push_back('{"bord_b",   2'd3, 16'h001F, 5,  23, 16'hFFFF});
        vecs.push_back('{"bord_in",  2'd3, 16'h001F, 5,  5,  16'h001F});
`endif

        // Reset state and startup cycle
        pix_if.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol, pix_if.frame_done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("startup_valid", pix_if.pix_valid, 1);
        check("startup_sof", pix_if.pix_sof, 1);
        check("startup_data", pix_if.pix_data, 16'hFFFF);
        check("startup_eol", pix_if.pix_eol, 0);

        // Table-driven pattern vectors
        foreach (vecs[i]) begin
            goto(vecs[i].m, vecs[i].c, vecs[i].x, vecs[i].y);
            check({vecs[i].name, "_data"}, pix_if.pix_data, with_border(vecs[i].x, vecs[i].y, vecs[i].data));
            check({vecs[i].name, "_sof"}, pix_if.pix_sof, (vecs[i].x == 0 && vecs[i].y == 0) ? 1 : 0);
            check({vecs[i].name, "_eol"}, pix_if.pix_eol, (vecs[i].x == H - 1) ? 1 : 0);
            check({vecs[i].name, "_valid"}, pix_if.pix_valid, 1);
        end

        // Mode change mid-frame takes effect only after the frame boundary
        goto(2'd1, 16'h0, 16, 0);
        mode = 2'd3;
        solid_color = 16'hABCD;
        pix_if.pix_ready = 1'b1;
        repeat (16 * H) @(negedge clk);
        pix_if.pix_ready = 1'b0;
        check("midframe_mode_ignored", pix_if.pix_data, with_border(16, 16, 16'hFFFF));
        pix_if.pix_ready = 1'b1;
        repeat ((V - 1) * H + (H - 1) - (16 * H + 16)) @(negedge clk);
        pix_if.pix_ready = 1'b0;
        check("last_pixel_eol", pix_if.pix_eol, 1);
        check("last_pixel_no_done", pix_if.frame_done, 0);
        pix_if.pix_ready = 1'b1;
        @(negedge clk);
        pix_if.pix_ready = 1'b0;
        check("wrap_frame_done", pix_if.frame_done, 1);
        check("wrap_sof", pix_if.pix_sof, 1);
        check("wrap_new_mode", pix_if.pix_data, with_border(0, 0, 16'hABCD));
        @(negedge clk);
        check("frame_done_one_cycle", pix_if.frame_done, 0);

        // Resync on a fire at the last pixel: restart, no frame_done
        goto(2'd0, 16'h0, H - 1, V - 1);
        mode = 2'd3;
        solid_color = 16'h5555;
        pix_if.pix_ready = 1'b1;
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        pix_if.pix_ready = 1'b0;
        check("resync_no_done", pix_if.frame_done, 0);
        check("resync_sof", pix_if.pix_sof, 1);
        check("resync_relatch", pix_if.pix_data, with_border(0, 0, 16'h5555));

        // Resync coinciding with a fire mid-frame
        goto(2'd0, 16'h0, 20, 5);
        pix_if.pix_ready = 1'b1;
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        pix_if.pix_ready = 1'b0;
        check("resync_mid_sof", pix_if.pix_sof, 1);
        check("resync_mid_data", pix_if.pix_data, 16'hFFFF);
        check("resync_mid_done", pix_if.frame_done, 0);

        // Random stalls over three frames
        goto(2'd0, 16'h0, 0, 0);
        fires = 0;
        frames = 0;
        px = 0;
        py = 0;
        cyc = 0;
        last_ready = 1'b0;
        s_data = pix_if.pix_data;
        s_sof = pix_if.pix_sof;
        s_eol = pix_if.pix_eol;
        while (fires < 3 * FR && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (last_ready) begin
                fires++;
                if (px == H - 1) begin
                    px = 0;
                    py = (py == V - 1) ? 0 : py + 1;
                end else begin
                    px++;
                end
            end else begin
                check("stall_data", pix_if.pix_data, s_data);
                check("stall_sof", pix_if.pix_sof, s_sof);
                check("stall_eol", pix_if.pix_eol, s_eol);
            end
            if (pix_if.frame_done) begin
                frames++;
                check("done_on_boundary", fires % FR, 0);
            end
            check("rand_sof", pix_if.pix_sof, (px == 0 && py == 0) ? 1 : 0);
            check("rand_eol", pix_if.pix_eol, (px == H - 1) ? 1 : 0);
            s_data = pix_if.pix_data;
            s_sof = pix_if.pix_sof;
            s_eol = pix_if.pix_eol;
            last_ready = ($urandom_range(0, 3) != 0);
            pix_if.pix_ready = last_ready;
        end
        pix_if.pix_ready = 1'b0;
        check("rand_fire_count", fires, 3 * FR);
        check("rand_frame_count", frames, 3);

        // Asynchronous reset mid-line clears outputs without a clock edge
        goto(2'd0, 16'h0, 10, 2);
        pix_if.pix_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset",
              {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol, pix_if.frame_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", pix_if.pix_valid, 1);
        check("post_reset_sof", pix_if.pix_sof, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
